// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared constants and types for the RTC bus scheduler and its step table.
package rtc_bus_scheduler_pkg;

    localparam logic [1:0] ID_INIT  = 2'd0;
    localparam logic [1:0] ID_FECHA = 2'd1;
    localparam logic [1:0] ID_HORA  = 2'd2;
    localparam logic [1:0] ID_READ  = 2'd3;

    localparam logic [3:0] SLOT_NONE   = 4'd0;
    localparam logic [3:0] SLOT_DIA    = 4'd1;
    localparam logic [3:0] SLOT_MES    = 4'd2;
    localparam logic [3:0] SLOT_ANIO   = 4'd3;
    localparam logic [3:0] SLOT_HORA   = 4'd4;
    localparam logic [3:0] SLOT_MIN    = 4'd5;
    localparam logic [3:0] SLOT_SEG    = 4'd6;
    localparam logic [3:0] SLOT_T_HORA = 4'd7;
    localparam logic [3:0] SLOT_T_MIN  = 4'd8;
    localparam logic [3:0] SLOT_T_SEG  = 4'd9;
    localparam logic [3:0] SLOT_INIT   = 4'd10;

    localparam logic [7:0] ADDR_CTRL   = 8'h02;
    localparam logic [7:0] ADDR_HORA   = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_SEG    = 8'h23;
    localparam logic [7:0] ADDR_DIA    = 8'h24;
    localparam logic [7:0] ADDR_MES    = 8'h25;
    localparam logic [7:0] ADDR_ANIO   = 8'h26;
    localparam logic [7:0] ADDR_T_HORA = 8'h41;
    localparam logic [7:0] ADDR_T_MIN  = 8'h42;
    localparam logic [7:0] ADDR_T_SEG  = 8'h43;

    localparam logic [7:0] CMD_WR_XFER = 8'hF1;
    localparam logic [7:0] CMD_RD_XFER = 8'hF0;

    localparam logic [3:0] LEN_INIT  = 4'd1;
    localparam logic [3:0] LEN_FECHA = 4'd4;
    localparam logic [3:0] LEN_HORA  = 4'd4;
    localparam logic [3:0] LEN_READ  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic       cmd;
        logic [3:0] slot;
        logic       last;
    } step_t;

    function automatic logic [3:0] step_count(input logic [1:0] id);
        case (id)
            ID_INIT:  step_count = LEN_INIT;
            ID_FECHA: step_count = LEN_FECHA;
            ID_HORA:  step_count = LEN_HORA;
            default:  step_count = LEN_READ;
        endcase
    endfunction

    function automatic step_t mk_step(input logic [7:0] a, input logic w,
                                      input logic c, input logic [3:0] s);
        mk_step = '{addr: a, wr: w, cmd: c, slot: s, last: 1'b0};
    endfunction

endpackage

// File: rtl/rtc_step_rom.sv
// Combinational step table: (requester id, step index) -> bus cycle description.
module rtc_step_rom
    import rtc_bus_scheduler_pkg::*;
(
    input  logic [1:0] id_i,
    input  logic [3:0] step_i,
    output step_t      step_o
);

    // Look up the cycle, then flag it as last when it is the final entry of the list.
    always_comb begin
        step_o = '0;
        case (id_i)
            ID_INIT: begin
                step_o = mk_step(ADDR_CTRL, 1'b1, 1'b0, SLOT_INIT);
            end
            ID_FECHA: begin
                case (step_i)
                    4'd0:    step_o = mk_step(ADDR_DIA,    1'b1, 1'b0, SLOT_DIA);
                    4'd1:    step_o = mk_step(ADDR_MES,    1'b1, 1'b0, SLOT_MES);
                    4'd2:    step_o = mk_step(ADDR_ANIO,   1'b1, 1'b0, SLOT_ANIO);
                    default: step_o = mk_step(CMD_WR_XFER, 1'b0, 1'b1, SLOT_NONE);
                endcase
            end
            ID_HORA: begin
                case (step_i)
                    4'd0:    step_o = mk_step(ADDR_HORA,   1'b1, 1'b0, SLOT_HORA);
                    4'd1:    step_o = mk_step(ADDR_MIN,    1'b1, 1'b0, SLOT_MIN);
                    4'd2:    step_o = mk_step(ADDR_SEG,    1'b1, 1'b0, SLOT_SEG);
                    default: step_o = mk_step(CMD_WR_XFER, 1'b0, 1'b1, SLOT_NONE);
                endcase
            end
            default: begin
                case (step_i)
                    4'd0:    step_o = mk_step(CMD_RD_XFER, 1'b0, 1'b1, SLOT_NONE);
                    4'd1:    step_o = mk_step(ADDR_HORA,   1'b0, 1'b0, SLOT_HORA);
                    4'd2:    step_o = mk_step(ADDR_MIN,    1'b0, 1'b0, SLOT_MIN);
                    4'd3:    step_o = mk_step(ADDR_SEG,    1'b0, 1'b0, SLOT_SEG);
                    4'd4:    step_o = mk_step(ADDR_DIA,    1'b0, 1'b0, SLOT_DIA);
                    4'd5:    step_o = mk_step(ADDR_MES,    1'b0, 1'b0, SLOT_MES);
                    4'd6:    step_o = mk_step(ADDR_ANIO,   1'b0, 1'b0, SLOT_ANIO);
                    4'd7:    step_o = mk_step(ADDR_T_HORA, 1'b0, 1'b0, SLOT_T_HORA);
                    4'd8:    step_o = mk_step(ADDR_T_MIN,  1'b0, 1'b0, SLOT_T_MIN);
                    4'd9:    step_o = mk_step(ADDR_T_SEG,  1'b0, 1'b0, SLOT_T_SEG);
                    default: step_o = '0;
                endcase
            end
        endcase
        step_o.last = (step_i == (step_count(id_i) - 4'd1));
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates four RTC bus requesters and walks the granted id's step list,
// one start/done bus cycle at a time, with a per-cycle timeout.
//
// state | meaning
// IDLE  | no transaction; grant highest-priority pending id
// ISSUE | bus_start pulse for the current step
// WAIT  | hold cycle fields, wait for bus_done or timeout
// NEXT  | advance to next step or finish the transaction
module rtc_bus_scheduler
    import rtc_bus_scheduler_pkg::*;
#(
    parameter int READ_PERIOD = 100000,
    parameter int TIMEOUT     = 255
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       req_init,
    input  logic       req_fecha,
    input  logic       req_hora,
    input  logic       en_auto_read,
    input  logic       bus_done,
    output logic       bus_start,
    output logic [7:0] bus_addr,
    output logic       bus_wr,
    output logic       bus_cmd,
    output logic [3:0] slot,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       txn_done,
    output logic       timeout_err
);

    localparam int RW = $clog2(READ_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(READ_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [3:0]    pend_q, pend_d, pend_clr;
    logic [1:0]    id_q, id_d, gnt_id;
    logic [3:0]    step_q, step_d;
    logic [RW-1:0] rd_tmr_q, rd_tmr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          txn_done_q, txn_done_d;
    logic          tmo_err_q, tmo_err_d;
    logic          rd_fire;
    step_t         cur_step;

    rtc_step_rom u_rom (
        .id_i   (id_q),
        .step_i (step_q),
        .step_o (cur_step)
    );

    // Periodic read-back timer; parked at zero while disabled.
    always_comb begin
        rd_fire  = en_auto_read && (rd_tmr_q == RD_LAST);
        rd_tmr_d = '0;
        if (en_auto_read && !rd_fire) begin
            rd_tmr_d = rd_tmr_q + RW'(1);
        end
    end

    // Fixed priority pick among pending ids: INIT > FECHA > HORA > READ.
    always_comb begin
        gnt_id = ID_READ;
        if (pend_q[ID_INIT]) begin
            gnt_id = ID_INIT;
        end else if (pend_q[ID_FECHA]) begin
            gnt_id = ID_FECHA;
        end else if (pend_q[ID_HORA]) begin
            gnt_id = ID_HORA;
        end
    end

    // Next-state logic; new requests win over the grant clear so a same-id request re-runs.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        step_d     = step_q;
        tmo_d      = tmo_q;
        txn_done_d = 1'b0;
        tmo_err_d  = 1'b0;
        pend_clr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    id_d             = gnt_id;
                    step_d           = '0;
                    pend_clr[gnt_id] = 1'b1;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_done) begin
                    state_d = ST_NEXT;
                end else if (tmo_q == '0) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            ST_NEXT: begin
                if (cur_step.last) begin
                    txn_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d = (pend_q & ~pend_clr) | {rd_fire, req_hora, req_fecha, req_init};
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            id_q       <= '0;
            step_q     <= '0;
            rd_tmr_q   <= '0;
            tmo_q      <= '0;
            txn_done_q <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            id_q       <= id_d;
            step_q     <= step_d;
            rd_tmr_q   <= rd_tmr_d;
            tmo_q      <= tmo_d;
            txn_done_q <= txn_done_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign bus_start   = (state_q == ST_ISSUE);
    assign bus_addr    = busy ? cur_step.addr : 8'h00;
    assign bus_wr      = busy & cur_step.wr;
    assign bus_cmd     = busy & cur_step.cmd;
    assign slot        = busy ? cur_step.slot : SLOT_NONE;
    assign active_id   = id_q;
    assign txn_done    = txn_done_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Sequences and shares the multiplexed address/data RTC bus among four requesters: chip init, date write, time write, and periodic read-back.
- Sits between the general control FSM and the bus-cycle signal generator. It picks one requester, then issues an ordered list of single bus cycles (command, write or read).
- Each cycle uses a start/done handshake. Alongside each cycle the block drives the register slot index that the data mux/demux uses.

Parameters:
- READ_PERIOD, 100000, clock cycles between automatic read-back requests (≥2).
- TIMEOUT, 255, maximum cycles to wait for bus_done before a transaction is aborted (≥1).

Ports:
- reloj  in  1  system clock
- resetM  in  1  synchronous reset, active-high
- req_init  in  1  pulse: run the INIT transaction
- req_fecha  in  1  pulse: run the date-write transaction
- req_hora  in  1  pulse: run the time-write transaction
- en_auto_read  in  1  enables the periodic read timer
- bus_done  in  1  bus-cycle generator has finished the current cycle
- bus_start  out  1  one-cycle pulse that launches a bus cycle
- bus_addr  out  8  RTC register/command address
- bus_wr  out  1  1 = write cycle, 0 = read cycle
- bus_cmd  out  1  1 = address-only command cycle (no data phase)
- slot  out  4  data slot index for the mux/demux; 0 = none
- busy  out  1  a transaction is in progress
- active_id  out  2  0 INIT, 1 FECHA, 2 HORA, 3 READ
- txn_done  out  1  one-cycle pulse when a transaction completes normally
- timeout_err  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags cleared; read timer and timeout counter cleared.
- Pending flags:
  - A req pulse sets pend[id] on the edge where it is sampled.
  - Repeated requests before service merge into one.
  - A request for the currently active id sets pend again, so that id re-runs after the current transaction.
- Read timer:
  - While en_auto_read=1, the timer counts; at READ_PERIOD-1 it sets pend[3] and wraps to 0.
  - While en_auto_read=0, the timer holds at 0.
- Arbitration: fixed priority INIT > FECHA > HORA > READ. It is evaluated only in IDLE. Granting an id clears its pend flag.
- Step lists (C = command, W = write, R = read; each entry is addr/slot):
  - INIT: W 0x02/10.
  - FECHA: W 0x24/1, W 0x25/2, W 0x26/3, C 0xF1/0.
  - HORA: W 0x21/4, W 0x22/5, W 0x23/6, C 0xF1/0.
  - READ: C 0xF0/0, R 0x21/4, 0x22/5, 0x23/6, 0x24/1, 0x25/2, 0x26/3, 0x41/7, 0x42/8, 0x43/9.
- FSM states: IDLE, ISSUE, WAIT, NEXT.
  - IDLE: if any pend flag is set, register the grant, step index 0, busy=1 → ISSUE.
  - ISSUE: bus_start=1 for exactly one cycle, with addr/wr/cmd/slot valid → WAIT.
  - WAIT: addr/wr/cmd/slot held stable. When bus_done=1 → NEXT. bus_done is sampled only in WAIT.
  - NEXT: if more steps remain, increment the step index → ISSUE. Otherwise txn_done=1, busy=0, slot=0 → IDLE.
- Latency:
  - A req sampled at edge 0 sets pend. The grant occurs at edge 1, and bus_start is high in the cycle after edge 1.
  - Two cycles elapse from bus_done being sampled to the next bus_start.
  - After txn_done, a new grant can occur at the following edge at the earliest.
- Timeout:
  - The counter runs only in WAIT. If it reaches TIMEOUT without bus_done, the transaction aborts.
  - On abort: timeout_err pulses, busy=0, slot=0, return to IDLE, and the remaining steps are dropped.
  - The pend flag for the aborted id is not re-set.
- Simultaneous events:
  - A req arriving in the same cycle as a grant to another id is latched; nothing is lost.
  - If the timer fires during READ, pend[3] is set again.
- resetM in any state takes effect at the next edge with all reset values above. No partial bus cycle is completed.

Decomposition:
- Shared package holds:
  - ID constants: ID_INIT, ID_FECHA, ID_HORA, ID_READ.
  - Slot constants: SLOT_NONE … SLOT_INIT.
  - RTC address constants: 0x02, 0x21–0x26, 0x41–0x43.
  - Command constants: CMD_WR_XFER=0xF1, CMD_RD_XFER=0xF0.
  - Step-list lengths.
- Sub-module rtc_step_rom: combinational lookup (id, step) → {addr, wr, cmd, slot, last}. The FSM stays independent of the tables.

Test Plan:
- After reset, pulse req_hora → bus_start three times with addr 0x21/0x22/0x23, wr=1, slot 4/5/6; then addr 0xF1 with cmd=1; txn_done once; busy low after.
- Pulse req_read via READ_PERIOD=20, en_auto_read=1, with bus_done 3 cycles after each start → 10 cycles, first 0xF0 cmd, slots 0,4,5,6,1,2,3,7,8,9, wr=0; timer re-fires every 20 cycles.
- Pulse req_fecha and req_init in the same cycle → INIT runs first (0x02, slot 10), then FECHA (0x24…0xF1); two txn_done pulses.
- Pulse req_hora twice during an active HORA → exactly one additional HORA transaction follows.
- Hold bus_done=0 with TIMEOUT=8 → timeout_err after 8 WAIT cycles; busy=0; next pending id served.
- Assert resetM during WAIT of FECHA step 2 → next edge: all outputs 0, pend cleared, no txn_done.
